// File: rtl/regfile_wr_arbiter.sv
// Round-robin arbiter that merges the ALU (A) and load (B) result streams
// onto the single register-file write port, with a saturating conflict counter.
module regfile_wr_arbiter #(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 5,
  parameter int CNT_W  = 16
) (
  input  logic              Clk,
  input  logic              Rst,
  input  logic              A_Valid,
  input  logic [ADDR_W-1:0] A_Addr,
  input  logic [DATA_W-1:0] A_Data,
  output logic              A_Ready,
  input  logic              B_Valid,
  input  logic [ADDR_W-1:0] B_Addr,
  input  logic [DATA_W-1:0] B_Data,
  output logic              B_Ready,
  output logic              Wr_En,
  output logic [ADDR_W-1:0] Wr_Addr,
  output logic [DATA_W-1:0] Wr_Data,
  output logic              Sel,
  output logic [CNT_W-1:0]  Conflict_Cnt
);

  typedef enum logic {LAST_A = 1'b0, LAST_B = 1'b1} last_t;

  localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};

  last_t             r_last;
  logic              r_wr_en;
  logic [ADDR_W-1:0] r_wr_addr;
  logic [DATA_W-1:0] r_wr_data;
  logic              r_sel;
  logic [CNT_W-1:0]  r_cnt;

  logic w_grant_a;
  logic w_grant_b;
  logic w_conflict;

  // Whoever was served last yields on a tie; the reset value of LAST_B makes A win first.
  assign w_conflict = A_Valid & B_Valid;
  assign w_grant_a  = ~Rst & A_Valid & (~B_Valid | (r_last == LAST_B));
  assign w_grant_b  = ~Rst & B_Valid & (~A_Valid | (r_last == LAST_A));

  assign A_Ready      = w_grant_a;
  assign B_Ready      = w_grant_b;
  assign Wr_En        = r_wr_en;
  assign Wr_Addr      = r_wr_addr;
  assign Wr_Data      = r_wr_data;
  assign Sel          = r_sel;
  assign Conflict_Cnt = r_cnt;

  always_ff @(posedge Clk or posedge Rst) begin
    if (Rst) begin
      r_last    <= LAST_B;
      r_wr_en   <= 1'b0;
      r_wr_addr <= '0;
      r_wr_data <= '0;
      r_sel     <= 1'b0;
      r_cnt     <= '0;
    end else begin
      if (w_grant_a) begin
        r_last    <= LAST_A;
        r_wr_en   <= (A_Addr != '0);
        r_wr_addr <= A_Addr;
        r_wr_data <= A_Data;
        r_sel     <= 1'b0;
      end else if (w_grant_b) begin
        r_last    <= LAST_B;
        r_wr_en   <= (B_Addr != '0);
        r_wr_addr <= B_Addr;
        r_wr_data <= B_Data;
        r_sel     <= 1'b1;
      end else begin
        r_wr_en   <= 1'b0;
      end
      // Saturate rather than wrap so a long stall never reads as few conflicts.
      if (w_conflict && (r_cnt != '1)) begin
        r_cnt <= r_cnt + CNT_ONE;
      end
    end
  end

endmodule

// File: tb/tb_regfile_wr_arbiter.sv
// Bench for regfile_wr_arbiter: directed scenarios with literal expectations
// plus randomized traffic compared every cycle against a behavioural model.
module tb_regfile_wr_arbiter;

  localparam int DW = 32;
  localparam int AW = 5;
  localparam int CW = 16;

  logic          Clk = 1'b0;
  logic          Rst = 1'b1;
  logic          A_Valid = 1'b0;
  logic [AW-1:0] A_Addr = '0;
  logic [DW-1:0] A_Data = '0;
  logic          B_Valid = 1'b0;
  logic [AW-1:0] B_Addr = '0;
  logic [DW-1:0] B_Data = '0;

  logic          A_Ready, B_Ready, Wr_En, Sel;
  logic [AW-1:0] Wr_Addr;
  logic [DW-1:0] Wr_Data;
  logic [CW-1:0] Conflict_Cnt;

  logic          A_Ready2, B_Ready2, Wr_En2, Sel2;
  logic [AW-1:0] Wr_Addr2;
  logic [DW-1:0] Wr_Data2;
  logic [1:0]    Conflict_Cnt2;

  int n_checks = 0;
  int n_fail   = 0;

  regfile_wr_arbiter #(.DATA_W(DW), .ADDR_W(AW), .CNT_W(CW)) u_dut (
    .Clk(Clk), .Rst(Rst),
    .A_Valid(A_Valid), .A_Addr(A_Addr), .A_Data(A_Data), .A_Ready(A_Ready),
    .B_Valid(B_Valid), .B_Addr(B_Addr), .B_Data(B_Data), .B_Ready(B_Ready),
    .Wr_En(Wr_En), .Wr_Addr(Wr_Addr), .Wr_Data(Wr_Data), .Sel(Sel),
    .Conflict_Cnt(Conflict_Cnt)
  );

  regfile_wr_arbiter #(.DATA_W(DW), .ADDR_W(AW), .CNT_W(2)) u_dut2 (
    .Clk(Clk), .Rst(Rst),
    .A_Valid(A_Valid), .A_Addr(A_Addr), .A_Data(A_Data), .A_Ready(A_Ready2),
    .B_Valid(B_Valid), .B_Addr(B_Addr), .B_Data(B_Data), .B_Ready(B_Ready2),
    .Wr_En(Wr_En2), .Wr_Addr(Wr_Addr2), .Wr_Data(Wr_Data2), .Sel(Sel2),
    .Conflict_Cnt(Conflict_Cnt2)
  );

  initial forever #5 Clk = ~Clk;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Behavioural model: the write port shows whatever was accepted on the last edge;
  // ties go to the requester not served most recently.
  bit            m_last_b = 1'b1;
  bit            m_en = 1'b0;
  logic [AW-1:0] m_addr = '0;
  logic [DW-1:0] m_data = '0;
  bit            m_sel = 1'b0;
  int            m_conf = 0;
  bit            m_any, m_win_b;

  initial forever begin
    @(negedge Clk);
    #2;
    if (Rst) begin
      m_last_b = 1'b1; m_en = 1'b0; m_addr = '0; m_data = '0; m_sel = 1'b0; m_conf = 0;
    end
    chk("m_wr_en",   {63'd0, Wr_En}, {63'd0, m_en});
    chk("m_wr_addr", {59'd0, Wr_Addr}, {59'd0, m_addr});
    chk("m_wr_data", {32'd0, Wr_Data}, {32'd0, m_data});
    chk("m_sel",     {63'd0, Sel}, {63'd0, m_sel});
    chk("m_cnt16",   {48'd0, Conflict_Cnt}, 64'((m_conf > 65535) ? 65535 : m_conf));
    chk("m_cnt2",    {62'd0, Conflict_Cnt2}, 64'((m_conf > 3) ? 3 : m_conf));
    if (Rst) begin
      chk("m_rst_ready", {62'd0, A_Ready, B_Ready}, 64'd0);
    end else begin
      m_any   = A_Valid || B_Valid;
      m_win_b = (A_Valid && B_Valid) ? !m_last_b : B_Valid;
      chk("m_a_ready", {63'd0, A_Ready}, {63'd0, m_any && !m_win_b});
      chk("m_b_ready", {63'd0, B_Ready}, {63'd0, m_any && m_win_b});
      if (A_Valid && B_Valid) m_conf++;
      if (m_any) begin
        m_addr   = m_win_b ? B_Addr : A_Addr;
        m_data   = m_win_b ? B_Data : A_Data;
        m_en     = (m_addr != 0);
        m_sel    = m_win_b;
        m_last_b = m_win_b;
      end else begin
        m_en = 1'b0;
      end
    end
  end

  task automatic idle_inputs();
    A_Valid = 1'b0; B_Valid = 1'b0; A_Addr = '0; B_Addr = '0; A_Data = '0; B_Data = '0;
  endtask

  task automatic reset_pulse();
    @(negedge Clk); Rst = 1'b1; idle_inputs();
    @(negedge Clk); Rst = 1'b0;
  endtask

  int aa_tab[6]  = '{1, 3, 3, 5, 5, 7};
  int bb_tab[6]  = '{2, 2, 4, 4, 6, 6};
  int cnt2_tab[6] = '{1, 2, 3, 3, 3, 3};

  initial begin
    // Reset holds Ready low even with a request pending.
    @(negedge Clk); A_Valid = 1'b1; A_Addr = 5'd3;
    #1 chk("rst_a_ready", {63'd0, A_Ready}, 64'd0);
    @(posedge Clk); #1;
    chk("rst_wr_en", {63'd0, Wr_En}, 64'd0);
    chk("rst_cnt", {48'd0, Conflict_Cnt}, 64'd0);
    @(negedge Clk); idle_inputs(); Rst = 1'b0;

    // Single A write.
    @(negedge Clk); A_Valid = 1'b1; A_Addr = 5'd8; A_Data = 32'h0F0F0F0F;
    #1 chk("a_ready", {63'd0, A_Ready}, 64'd1);
    @(posedge Clk); #1;
    chk("a_wr_en", {63'd0, Wr_En}, 64'd1);
    chk("a_wr_addr", {59'd0, Wr_Addr}, 64'd8);
    chk("a_wr_data", {32'd0, Wr_Data}, 64'h0F0F0F0F);
    chk("a_sel", {63'd0, Sel}, 64'd0);

    // B write to register 0 is consumed without a write.
    @(negedge Clk); idle_inputs(); B_Valid = 1'b1; B_Addr = 5'd0; B_Data = 32'hFFFFFFFF;
    #1 chk("b0_ready", {63'd0, B_Ready}, 64'd1);
    @(posedge Clk); #1;
    chk("b0_wr_en", {63'd0, Wr_En}, 64'd0);
    chk("b0_sel", {63'd0, Sel}, 64'd1);

    // Contention after reset: A first, strict alternation, counters count and saturate.
    reset_pulse();
    for (int k = 0; k < 6; k++) begin
      @(negedge Clk);
      A_Valid = 1'b1; B_Valid = 1'b1;
      A_Addr = AW'(aa_tab[k]); B_Addr = AW'(bb_tab[k]);
      A_Data = 32'hA000_0000 + 32'(k); B_Data = 32'hB000_0000 + 32'(k);
      #1 chk("alt_a_ready", {63'd0, A_Ready}, {63'd0, (k % 2) == 0});
      @(posedge Clk); #1;
      chk("alt_sel", {63'd0, Sel}, {63'd0, (k % 2) == 1});
      chk("alt_wr_addr", {59'd0, Wr_Addr}, 64'(k + 1));
      chk("alt_cnt16", {48'd0, Conflict_Cnt}, 64'(k + 1));
      chk("alt_cnt2", {62'd0, Conflict_Cnt2}, 64'(cnt2_tab[k]));
    end

    // Reset lands while A is being granted: output clears at once, grant is lost.
    @(negedge Clk); idle_inputs(); B_Valid = 1'b1; B_Addr = 5'd7; B_Data = 32'h1234;
    @(negedge Clk); idle_inputs(); A_Valid = 1'b1; A_Addr = 5'd9; A_Data = 32'h5678;
    #1 chk("mid_a_ready", {63'd0, A_Ready}, 64'd1);
    chk("mid_pre_wr_en", {63'd0, Wr_En}, 64'd1);
    Rst = 1'b1;
    #1;
    chk("mid_wr_en", {63'd0, Wr_En}, 64'd0);
    chk("mid_a_ready_rst", {63'd0, A_Ready}, 64'd0);
    chk("mid_cnt", {48'd0, Conflict_Cnt}, 64'd0);
    @(negedge Clk); idle_inputs(); Rst = 1'b0;
    @(posedge Clk); #1;
    chk("mid_no_write", {63'd0, Wr_En}, 64'd0);

    // Randomized traffic with occasional resets; the model process checks every cycle.
    for (int i = 0; i < 1500; i++) begin
      @(negedge Clk);
      Rst     = ($urandom_range(0, 99) == 0);
      A_Valid = ($urandom_range(0, 3) != 0);
      B_Valid = ($urandom_range(0, 3) != 0);
      A_Addr  = AW'($urandom_range(0, 31));
      B_Addr  = AW'($urandom_range(0, 31));
      A_Data  = $urandom;
      B_Data  = $urandom;
    end
    @(negedge Clk); idle_inputs(); Rst = 1'b0;
    repeat (2) @(negedge Clk);
    #4;
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout, expected end of stimulus");
    $fatal(1, "watchdog expired");
  end

endmodule

// File: doc/regfile_wr_arbiter.md
REGFILE_WR_ARBITER -- requirements
Module: regfile_wr_arbiter

Interface
REQ-001 SHALL have parameter DATA_W, default 32, write-data width.
REQ-002 SHALL have parameter ADDR_W, default 5, register-address width.
REQ-003 SHALL have parameter CNT_W, default 16, conflict-counter width.
REQ-004 SHALL have port Clk  input  1  single clock; all state on rising edge.
REQ-005 SHALL have port Rst  input  1  reset, asynchronous, active-high.
REQ-006 SHALL have port A_Valid  input  1  requester A (ALU result) has a write.
REQ-007 SHALL have port A_Addr  input  ADDR_W  requester A destination register.
REQ-008 SHALL have port A_Data  input  DATA_W  requester A write data.
REQ-009 SHALL have port A_Ready  output  1  requester A granted this cycle.
REQ-010 SHALL have ports B_Valid, B_Addr, B_Data, B_Ready with the same directions, widths and meaning for requester B (memory load result).
REQ-011 SHALL have port Wr_En  output  1  register-file write enable.
REQ-012 SHALL have port Wr_Addr  output  ADDR_W  register-file write address.
REQ-013 SHALL have port Wr_Data  output  DATA_W  register-file write data.
REQ-014 SHALL have port Sel  output  1  source select for the 32-bit 2:1 write-data mux; 0 = A, 1 = B.
REQ-015 SHALL have port Conflict_Cnt  output  CNT_W  count of cycles with both requesters valid.

Function
REQ-016 SHALL hold a one-bit priority state Last with values LAST_A and LAST_B, recording the last granted requester.
REQ-017 SHALL grant A only when A_Valid=1 and (B_Valid=0 or Last=LAST_B); SHALL grant B only when B_Valid=1 and (A_Valid=0 or Last=LAST_A).
REQ-018 SHALL drive A_Ready/B_Ready combinationally from the grant, at most one high per cycle; a transfer occurs when Valid and Ready are both high on a rising edge.
REQ-019 SHALL never assert Ready for a requester whose Valid is low.
REQ-020 SHALL update Last only on a cycle with a grant; SHALL hold Last when idle.
REQ-021 SHALL register the granted Addr and Data into Wr_Addr and Wr_Data, with 1-cycle latency from the transfer edge.
REQ-022 SHALL set Wr_En=1 in the cycle after a transfer only if the transferred address is nonzero.
REQ-023 SHALL accept and consume a transfer to address 0, without asserting Wr_En.
REQ-024 SHALL set Wr_En=0 in any cycle following a cycle with no grant.
REQ-025 SHALL register Sel with the granted source on every grant; SHALL hold Sel when idle.
REQ-026 SHALL guarantee that a continuously valid requester waits at most one cycle for a grant, with strict alternation A,B,A,B while both stay valid.
REQ-027 SHALL increment Conflict_Cnt by 1 on every edge where A_Valid=B_Valid=1; SHALL saturate at all-ones with no wrap.
REQ-028 SHALL not apply backpressure from the register file; the output stage accepts every cycle.

Reset
REQ-029 SHALL, while Rst=1, force Wr_En=0, Wr_Addr=0, Wr_Data=0, Sel=0, Conflict_Cnt=0 and Last=LAST_B, asynchronously.
REQ-030 SHALL hold A_Ready=B_Ready=0 while Rst=1.
REQ-031 SHALL, on reset during operation, discard any grant in that cycle with no later write.
REQ-032 SHALL, after Rst falls, grant A first on a simultaneous request.

Verification
REQ-033 SHALL cover: reset release; A_Valid=1, A_Addr=8, A_Data=32'h0F0F0F0F, B idle -> A_Ready=1 same cycle; next cycle Wr_En=1, Wr_Addr=8, Wr_Data=32'h0F0F0F0F, Sel=0.
REQ-034 SHALL cover: A and B both valid for 4 cycles with distinct addresses 1-4 -> grants A,B,A,B; Sel 0,1,0,1; Conflict_Cnt=4.
REQ-035 SHALL cover: B_Valid=1, B_Addr=0, B_Data=32'hFFFFFFFF -> B_Ready=1; next cycle Wr_En=0, Sel=1.
REQ-036 SHALL cover: Rst asserted mid-cycle while A granted -> Wr_En=0 immediately, no write after release, Conflict_Cnt=0.
REQ-037 SHALL cover: CNT_W=2, both valid 6 cycles -> Conflict_Cnt reads 1,2,3,3,3,3.
